// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Definitions shared by the host responder and the DMA engine:
//   - tuser field offsets (address, read-request code, kind, length)
//   - kind codes and the read-request code
//   - responder FSM state type
//   - make_tuser(): packs the tuser sideband from its fields
// -----------------------------------------------------------------------------
package dma_pkg;

    localparam int TUSER_W         = 96;
    localparam int TUSER_ADDR_LSB  = 64;   // [95:64] word address
    localparam int TUSER_RDREQ_LSB = 27;   // [31:27] read-request code
    localparam int TUSER_KIND_LSB  = 24;   // [26:24] beat kind
    localparam int TUSER_LEN_LSB   = 0;    // [7:0]   length

    localparam logic [2:0] KIND_WRDATA   = 3'b001;
    localparam logic [2:0] KIND_DOORBELL = 3'b010;
    localparam logic [2:0] KIND_CPL      = 3'b100;

    localparam logic [4:0] RDREQ_CODE = 5'b00001;

    typedef enum logic [2:0] {
        IDLE,
        DOORBELL,
        WAIT_RDREQ,
        CPL,
        WAIT_DATA,
        FINISH
    } dma_state_t;

    function automatic logic [TUSER_W-1:0] make_tuser(
        input logic [31:0] addr,
        input logic [2:0]  kind,
        input logic [7:0]  len
    );
        logic [TUSER_W-1:0] t;
        t = '0;
        t[TUSER_ADDR_LSB +: 32] = addr;
        t[TUSER_KIND_LSB +: 3]  = kind;
        t[TUSER_LEN_LSB +: 8]   = len;
        return t;
    endfunction

endpackage

// File: rtl/dma_host_mem.sv
// -----------------------------------------------------------------------------
// dma_host_mem
// Host memory model: MEM_DEPTH x 32 bits, one synchronous write port and one
// combinational read port. Contents are not reset.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write word address
//   wdata - write data
//   raddr - read word address
//   rdata - read data (combinational)
// -----------------------------------------------------------------------------
module dma_host_mem #(
    parameter int MEM_DEPTH = 256,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dma_host_responder.sv
// -----------------------------------------------------------------------------
// dma_host_responder
// Host-side model of a DMA job: rings a doorbell, waits for the engine's read
// request, returns the descriptor as a completion, then stores the write-data
// beats into host memory.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   start, cfg_src/dst/len - job request and descriptor
//   host_dma_*             - outbound stream (doorbell, completion)
//   dma_host_*             - inbound stream (read request, write data)
//   busy, done, err        - status (done is a pulse, err is sticky)
//   beat_cnt               - accepted write-data beats of the current job
//   rd_addr, rd_data       - combinational host-memory read port
// -----------------------------------------------------------------------------
module dma_host_responder
    import dma_pkg::*;
#(
    parameter int  MEM_DEPTH = 256,
    parameter int  TIMEOUT   = 1024,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [31:0]   cfg_src,
    input  logic [31:0]   cfg_dst,
    input  logic [7:0]    cfg_len,
    output logic          host_dma_tvalid,
    input  logic          host_dma_tready,
    output logic          host_dma_tlast,
    output logic [95:0]   host_dma_tuser,
    output logic [127:0]  host_dma_tdata,
    input  logic          dma_host_tvalid,
    output logic          dma_host_tready,
    input  logic          dma_host_tlast,
    input  logic [95:0]   dma_host_tuser,
    input  logic [31:0]   dma_host_tdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [7:0]    beat_cnt,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT - 1);

    dma_state_t  state_reg, state_next;
    logic [31:0] src_reg, src_next;
    logic [31:0] dst_reg, dst_next;
    logic [7:0]  len_reg, len_next;
    logic [7:0]  beat_reg, beat_next;
    logic        err_reg, err_next;
    logic [31:0] wd_reg, wd_next;

    logic        tx_fire, rx_fire, watch, timeout;
    logic [8:0]  beat_inc;
    logic        rx_final, rx_kind_ok, rx_bad;
    logic [31:0] addr_sum;
    logic        mem_we;
    logic        unused_bits;

    assign tx_fire    = host_dma_tvalid & host_dma_tready;
    assign rx_fire    = dma_host_tvalid & dma_host_tready;
    assign watch      = state_reg inside {DOORBELL, WAIT_RDREQ, CPL, WAIT_DATA};
    // Fires on the TIMEOUT-th consecutive cycle without a transfer.
    assign timeout    = watch && !(tx_fire || rx_fire) && (wd_reg == WD_LIMIT);

    assign beat_inc   = {1'b0, beat_reg} + 9'd1;
    assign rx_final   = (beat_inc == {1'b0, len_reg});
    assign rx_kind_ok = (dma_host_tuser[TUSER_KIND_LSB +: 3] == KIND_WRDATA);
    // tlast before the final beat, or a foreign kind, aborts the job unwritten.
    assign rx_bad     = !rx_kind_ok || (dma_host_tlast && !rx_final);
    // Truncation to AW bits gives the modulo-MEM_DEPTH wrap.
    assign addr_sum   = dma_host_tuser[TUSER_ADDR_LSB +: 32] + {24'd0, beat_reg};

    assign unused_bits = ^{dma_host_tuser[63:32], dma_host_tuser[23:0], addr_sum[31:AW]};

    always_comb begin
        state_next = state_reg;
        src_next   = src_reg;
        dst_next   = dst_reg;
        len_next   = len_reg;
        beat_next  = beat_reg;
        err_next   = err_reg;
        mem_we     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    src_next   = cfg_src;
                    dst_next   = cfg_dst;
                    len_next   = cfg_len;
                    beat_next  = 8'd0;
                    err_next   = 1'b0;
                    state_next = DOORBELL;
                end
            end
            DOORBELL: begin
                if (tx_fire) state_next = WAIT_RDREQ;
            end
            WAIT_RDREQ: begin
                if (rx_fire) begin
                    if (dma_host_tuser[TUSER_RDREQ_LSB +: 5] == RDREQ_CODE) begin
                        state_next = CPL;
                    end else begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            CPL: begin
                if (tx_fire) state_next = (len_reg == 8'd0) ? FINISH : WAIT_DATA;
            end
            WAIT_DATA: begin
                if (rx_fire) begin
                    if (rx_bad) begin
                        err_next   = 1'b1;
                        state_next = FINISH;
                    end else begin
                        mem_we    = 1'b1;
                        beat_next = beat_inc[7:0];
                        if (rx_final) state_next = FINISH;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (timeout) begin
            err_next   = 1'b1;
            state_next = IDLE;
        end
    end

    // Watchdog restarts on every transfer and on every state change.
    always_comb begin
        wd_next = wd_reg + 32'd1;
        if (!watch || tx_fire || rx_fire || (state_next != state_reg)) begin
            wd_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            src_reg   <= '0;
            dst_reg   <= '0;
            len_reg   <= '0;
            beat_reg  <= '0;
            err_reg   <= 1'b0;
            wd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            src_reg   <= src_next;
            dst_reg   <= dst_next;
            len_reg   <= len_next;
            beat_reg  <= beat_next;
            err_reg   <= err_next;
            wd_reg    <= wd_next;
        end
    end

    // Stream outputs decode straight from the state register, so they stay
    // stable while waiting for tready and drop at once on reset.
    always_comb begin
        host_dma_tvalid = 1'b0;
        host_dma_tlast  = 1'b0;
        host_dma_tuser  = '0;
        host_dma_tdata  = '0;
        dma_host_tready = 1'b0;
        case (state_reg)
            DOORBELL: begin
                host_dma_tvalid = 1'b1;
                host_dma_tlast  = 1'b1;
                host_dma_tuser  = make_tuser(32'd0, KIND_DOORBELL, 8'd0);
            end
            CPL: begin
                host_dma_tvalid = 1'b1;
                host_dma_tlast  = 1'b1;
                host_dma_tuser  = make_tuser(32'd0, KIND_CPL, 8'd1);
                host_dma_tdata  = {32'd0, 24'd0, len_reg, dst_reg, src_reg};
            end
            WAIT_RDREQ, WAIT_DATA: begin
                dma_host_tready = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == FINISH);
    assign err      = err_reg;
    assign beat_cnt = beat_reg;

    dma_host_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (addr_sum[AW-1:0]),
        .wdata (dma_host_tdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule
